// File: rtl/piso_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : piso_ctrl_if
//  Purpose  : Bundles the word handshake and framed serial output of
//             piso_ctrl into one interface.
//  Signals  : valid_i       upstream word valid
//             ready_o       block accepts a word this cycle
//             data_i        parallel word (WIDTH bits)
//             data_o        serial bit, 0 outside a frame
//             sout_valid_o  data_o carries a frame bit
//             sof_o         first bit of a frame
//             eof_o         last bit of a frame
//             busy_o        frame or inter-frame gap in progress
//  Modports : master (word producer / serial consumer), slave (piso_ctrl)
//  Revision : 1.0 - initial release
// ============================================================================
interface piso_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] data_i;
    logic             data_o;
    logic             sout_valid_o;
    logic             sof_o;
    logic             eof_o;
    logic             busy_o;

    modport master (
        output valid_i, data_i,
        input  ready_o, data_o, sout_valid_o, sof_o, eof_o, busy_o
    );

    modport slave (
        input  valid_i, data_i,
        output ready_o, data_o, sout_valid_o, sof_o, eof_o, busy_o
    );
endinterface
`default_nettype wire

// File: rtl/piso_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : piso_ctrl
//  Purpose  : Parallel-in / serial-out sequencing controller. Takes words
//             over a valid/ready handshake and emits each one as a framed
//             bit stream with start/end-of-frame markers and an optional
//             idle gap between frames.
//  Ports    : clk_i  - clock, all state updates on posedge
//             rst_i  - synchronous reset, active-high
//             bus    - piso_ctrl_if.slave (handshake + serial outputs)
//  Params   : WIDTH (2..32), MSB_FIRST (1 = MSB first), GAP (0..15)
//  Options  : define PISO_CTRL_PARITY_EN to append an even-parity bit to
//             every frame (frame length WIDTH+1).
//  Revision : 1.0 - initial release
// ============================================================================
module piso_ctrl #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1,
    parameter int GAP       = 0
) (
    input  wire logic   clk_i,
    input  wire logic   rst_i,
    piso_ctrl_if.slave  bus
);

    localparam int                 c_CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST     = c_CNT_W'(WIDTH - 1);
    localparam logic [3:0]         c_GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    // A new word may be taken on the last frame cycle only when nothing
    // (parity bit or gap) follows it; with parity that cycle is the parity bit.
`ifdef PISO_CTRL_PARITY_EN
    localparam bit c_RDY_ON_LAST_DATA = 1'b0;
`else
    localparam bit c_RDY_ON_LAST_DATA = (GAP == 0);
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_GAP    = 2'd2
`ifdef PISO_CTRL_PARITY_EN
        ,
        S_PARITY = 2'd3
`endif
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_shreg;
    logic [c_CNT_W-1:0] r_bit_cnt;
    logic [3:0]         r_gap_cnt;
`ifdef PISO_CTRL_PARITY_EN
    logic               r_par;
    logic               w_par_nxt;
`endif

    // Registered copies of the serial outputs
    logic               r_data;
    logic               r_sout_valid;
    logic               r_sof;
    logic               r_eof;
    logic               r_busy;
    logic               r_ready;

    state_t             w_state_nxt;
    logic [WIDTH-1:0]   w_shreg_nxt;
    logic [WIDTH-1:0]   w_shifted;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [3:0]         w_gap_nxt;
    logic               w_ready;
    logic               w_take;
    logic               w_load;
    logic               w_data_nxt;
    logic               w_sv_nxt;
    logic               w_sof_nxt;
    logic               w_eof_nxt;
    logic               w_ready_nxt;

    // Reset masks ready so no word is taken while rst_i is high.
    assign w_ready = r_ready & ~rst_i;
    assign w_take  = bus.valid_i & w_ready;

    // ------------------------------------------------------------------
    // Next-state and next-output computation
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_cnt_nxt   = r_bit_cnt;
        w_gap_nxt   = r_gap_cnt;
        w_load      = 1'b0;
`ifdef PISO_CTRL_PARITY_EN
        w_par_nxt   = r_par;
`endif
        // Shift toward the output end with zero fill
        w_shifted   = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0}
                                : {1'b0, r_shreg[WIDTH-1:1]};

        case (r_state)
            S_IDLE: begin
                w_load = w_take;
            end
            S_SHIFT: begin
                w_shreg_nxt = w_shifted;
                if (r_bit_cnt == c_LAST) begin
`ifdef PISO_CTRL_PARITY_EN
                    w_state_nxt = S_PARITY;
`else
                    if (GAP > 0) begin
                        w_state_nxt = S_GAP;
                        w_gap_nxt   = c_GAP_LOAD;
                    end else if (w_take) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
`endif
                end else begin
                    w_cnt_nxt = r_bit_cnt + c_CNT_W'(1);
                end
            end
`ifdef PISO_CTRL_PARITY_EN
            S_PARITY: begin
                if (GAP > 0) begin
                    w_state_nxt = S_GAP;
                    w_gap_nxt   = c_GAP_LOAD;
                end else if (w_take) begin
                    w_load = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
`endif
            S_GAP: begin
                if (r_gap_cnt == 4'd0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_gap_nxt = r_gap_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_load) begin
            w_state_nxt = S_SHIFT;
            w_shreg_nxt = bus.data_i;
            w_cnt_nxt   = '0;
`ifdef PISO_CTRL_PARITY_EN
            w_par_nxt   = ^bus.data_i;
`endif
        end

        // Outputs decoded from the next registered state so that they can be
        // registered alongside it.
        w_data_nxt  = 1'b0;
        w_sv_nxt    = 1'b0;
        w_sof_nxt   = 1'b0;
        w_eof_nxt   = 1'b0;
        w_ready_nxt = 1'b0;
        case (w_state_nxt)
            S_IDLE: begin
                w_ready_nxt = 1'b1;
            end
            S_SHIFT: begin
                w_sv_nxt    = 1'b1;
                w_data_nxt  = MSB_FIRST ? w_shreg_nxt[WIDTH-1] : w_shreg_nxt[0];
                w_sof_nxt   = (w_cnt_nxt == '0);
                w_eof_nxt   = (w_cnt_nxt == c_LAST) && c_RDY_ON_LAST_DATA;
`ifndef PISO_CTRL_PARITY_EN
                w_eof_nxt   = (w_cnt_nxt == c_LAST);
`endif
                w_ready_nxt = (w_cnt_nxt == c_LAST) && c_RDY_ON_LAST_DATA;
            end
`ifdef PISO_CTRL_PARITY_EN
            S_PARITY: begin
                w_sv_nxt    = 1'b1;
                w_data_nxt  = w_par_nxt;
                w_eof_nxt   = 1'b1;
                w_ready_nxt = (GAP == 0);
            end
`endif
            default: begin
                w_ready_nxt = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_shreg      <= '0;
            r_bit_cnt    <= '0;
            r_gap_cnt    <= 4'd0;
`ifdef PISO_CTRL_PARITY_EN
            r_par        <= 1'b0;
`endif
            r_data       <= 1'b0;
            r_sout_valid <= 1'b0;
            r_sof        <= 1'b0;
            r_eof        <= 1'b0;
            r_busy       <= 1'b0;
            r_ready      <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_shreg      <= w_shreg_nxt;
            r_bit_cnt    <= w_cnt_nxt;
            r_gap_cnt    <= w_gap_nxt;
`ifdef PISO_CTRL_PARITY_EN
            r_par        <= w_par_nxt;
`endif
            r_data       <= w_data_nxt;
            r_sout_valid <= w_sv_nxt;
            r_sof        <= w_sof_nxt;
            r_eof        <= w_eof_nxt;
            r_busy       <= (w_state_nxt != S_IDLE);
            r_ready      <= w_ready_nxt;
        end
    end

    assign bus.ready_o      = w_ready;
    assign bus.data_o       = r_data;
    assign bus.sout_valid_o = r_sout_valid;
    assign bus.sof_o        = r_sof;
    assign bus.eof_o        = r_eof;
    assign bus.busy_o       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_piso_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_piso_ctrl
//  Purpose  : Directed self-checking bench for piso_ctrl. Four instances:
//             a (WIDTH 4, MSB first, GAP 0), b (LSB first), c (GAP 2),
//             d (WIDTH 2). Expected streams are built from the word itself.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_piso_ctrl;

`ifdef PISO_CTRL_PARITY_EN
    localparam int c_PAR = 1;
`else
    localparam int c_PAR = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] tb_valid;
    logic [3:0] tb_data;
    int         sel;
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 clk = ~clk;

    piso_ctrl_if #(.WIDTH(4)) bus_a ();
    piso_ctrl_if #(.WIDTH(4)) bus_b ();
    piso_ctrl_if #(.WIDTH(4)) bus_c ();
    piso_ctrl_if #(.WIDTH(2)) bus_d ();

    assign bus_a.valid_i = tb_valid[0];
    assign bus_b.valid_i = tb_valid[1];
    assign bus_c.valid_i = tb_valid[2];
    assign bus_d.valid_i = tb_valid[3];
    assign bus_a.data_i  = tb_data;
    assign bus_b.data_i  = tb_data;
    assign bus_c.data_i  = tb_data;
    assign bus_d.data_i  = tb_data[1:0];

    piso_ctrl #(.WIDTH(4), .MSB_FIRST(1'b1), .GAP(0)) u_dut_a (.clk_i(clk), .rst_i(rst), .bus(bus_a.slave));
    piso_ctrl #(.WIDTH(4), .MSB_FIRST(1'b0), .GAP(0)) u_dut_b (.clk_i(clk), .rst_i(rst), .bus(bus_b.slave));
    piso_ctrl #(.WIDTH(4), .MSB_FIRST(1'b1), .GAP(2)) u_dut_c (.clk_i(clk), .rst_i(rst), .bus(bus_c.slave));
    piso_ctrl #(.WIDTH(2), .MSB_FIRST(1'b1), .GAP(0)) u_dut_d (.clk_i(clk), .rst_i(rst), .bus(bus_d.slave));

    // Observed outputs of the selected instance
    logic s_data, s_sv, s_sof, s_eof, s_busy, s_ready;
    always_comb begin
        s_data = 1'b0; s_sv = 1'b0; s_sof = 1'b0; s_eof = 1'b0; s_busy = 1'b0; s_ready = 1'b0;
        case (sel)
            0: begin s_data = bus_a.data_o; s_sv = bus_a.sout_valid_o; s_sof = bus_a.sof_o;
                     s_eof = bus_a.eof_o; s_busy = bus_a.busy_o; s_ready = bus_a.ready_o; end
            1: begin s_data = bus_b.data_o; s_sv = bus_b.sout_valid_o; s_sof = bus_b.sof_o;
                     s_eof = bus_b.eof_o; s_busy = bus_b.busy_o; s_ready = bus_b.ready_o; end
            2: begin s_data = bus_c.data_o; s_sv = bus_c.sout_valid_o; s_sof = bus_c.sof_o;
                     s_eof = bus_c.eof_o; s_busy = bus_c.busy_o; s_ready = bus_c.ready_o; end
            default: begin s_data = bus_d.data_o; s_sv = bus_d.sout_valid_o; s_sof = bus_d.sof_o;
                     s_eof = bus_d.eof_o; s_busy = bus_d.busy_o; s_ready = bus_d.ready_o; end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic par_of(input logic [31:0] word, input int w);
        logic p;
        p = 1'b0;
        for (int i = 0; i < w; i++) p = p ^ word[i];
        return p;
    endfunction

    // Checks frame cycles first..last, sampling each on a negedge.
    task automatic expect_frame(input int d, input logic [31:0] word, input int w,
                                input bit msb, input bit rdy_last, input int first);
        int   fl;
        logic b;
        fl  = w + c_PAR;
        sel = d;
        for (int i = first; i < fl; i++) begin
            @(negedge clk);
            if (i < w) b = msb ? word[w-1-i] : word[i];
            else       b = par_of(word, w);
            check($sformatf("d%0d w%0h bit%0d data", d, word, i), s_data, b);
            check($sformatf("d%0d w%0h bit%0d valid", d, word, i), s_sv, 1);
            check($sformatf("d%0d w%0h bit%0d sof", d, word, i), s_sof, (i == 0));
            check($sformatf("d%0d w%0h bit%0d eof", d, word, i), s_eof, (i == fl - 1));
            check($sformatf("d%0d w%0h bit%0d ready", d, word, i), s_ready, (rdy_last && i == fl - 1));
            check($sformatf("d%0d w%0h bit%0d busy", d, word, i), s_busy, 1);
        end
    endtask

    // One-cycle valid pulse from IDLE, ready checked before the accept edge.
    task automatic send_word(input int d, input logic [3:0] word);
        sel = d;
        @(posedge clk); #1;
        tb_valid[d] = 1'b1;
        tb_data     = word;
        @(negedge clk);
        check($sformatf("d%0d ready before accept", d), s_ready, 1);
        @(posedge clk); #1;
        tb_valid[d] = 1'b0;
    endtask

    task automatic expect_idle(input int d, input string tag);
        sel = d;
        @(negedge clk);
        check({tag, " valid"}, s_sv, 0);
        check({tag, " busy"}, s_busy, 0);
        check({tag, " data"}, s_data, 0);
        check({tag, " ready"}, s_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  idle;
        bit  seen;
        rst      = 1'b1;
        tb_valid = '0;
        tb_data  = '0;
        sel      = 0;

        // Reset: ready held low while rst is high, idle outputs afterwards
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            sel = d; #1;
            check($sformatf("d%0d ready in reset", d), s_ready, 0);
            check($sformatf("d%0d valid in reset", d), s_sv, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            sel = d; #1;
            check($sformatf("d%0d rst ready", d), s_ready, 1);
            check($sformatf("d%0d rst busy", d), s_busy, 0);
            check($sformatf("d%0d rst valid", d), s_sv, 0);
            check($sformatf("d%0d rst sof/eof", d), {s_sof, s_eof, s_data}, 3'b000);
        end

        // Single word, MSB first: 1,0,1,0
        send_word(0, 4'hA);
        expect_frame(0, 32'hA, 4, 1'b1, 1'b1, 0);
        expect_idle(0, "a after A");

        // Back-to-back A then 5: contiguous stream
        sel = 0;
        @(posedge clk); #1;
        tb_valid[0] = 1'b1;
        tb_data     = 4'hA;
        @(posedge clk); #1;
        tb_data     = 4'h5;
        expect_frame(0, 32'hA, 4, 1'b1, 1'b1, 0);
        @(posedge clk); #1;
        tb_valid[0] = 1'b0;
        expect_frame(0, 32'h5, 4, 1'b1, 1'b1, 0);
        expect_idle(0, "a after b2b");

        // LSB first: 6 -> 0,1,1,0
        send_word(1, 4'h6);
        expect_frame(1, 32'h6, 4, 1'b0, 1'b1, 0);
        expect_idle(1, "b after 6");

        // GAP = 2: three idle cycles between eof and next sof
        sel = 2;
        @(posedge clk); #1;
        tb_valid[2] = 1'b1;
        tb_data     = 4'hA;
        @(posedge clk); #1;
        tb_data     = 4'h5;
        expect_frame(2, 32'hA, 4, 1'b1, 1'b0, 0);
        idle = 0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (k == 0) begin
                check("c gap ready", s_ready, 0);
                check("c gap busy", s_busy, 1);
            end
            if (s_sof) seen = 1'b1;
            else if (!s_sv) idle++;
        end
        tb_valid[2] = 1'b0;
        check("c second sof seen", seen, 1);
        check("c idle cycles", idle, 3);
        check("c second bit0", s_data, 0);
        expect_frame(2, 32'h5, 4, 1'b1, 1'b0, 1);
        @(negedge clk);
        check("c gap after 5 valid", s_sv, 0);
        check("c gap after 5 ready", s_ready, 0);
        repeat (4) @(negedge clk);
        check("c idle ready", s_ready, 1);

        // Reset during bit 2 of A aborts the frame
        send_word(0, 4'hA);
        @(negedge clk);
        check("a abort bit1", s_data, 1);
        @(negedge clk);
        check("a abort bit2", s_data, 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("a abort valid", s_sv, 0);
        check("a abort eof", s_eof, 0);
        check("a abort busy", s_busy, 0);
        check("a abort ready in rst", s_ready, 0);
        rst = 1'b0;
        #1;
        check("a abort ready after rst", s_ready, 1);
        send_word(0, 4'h5);
        expect_frame(0, 32'h5, 4, 1'b1, 1'b1, 0);
        expect_idle(0, "a after abort");

        // Parity words (odd and even parity) and WIDTH 2 boundary
        send_word(0, 4'h7);
        expect_frame(0, 32'h7, 4, 1'b1, 1'b1, 0);
        send_word(0, 4'h3);
        expect_frame(0, 32'h3, 4, 1'b1, 1'b1, 0);
        expect_idle(0, "a after 3");
        send_word(3, 4'h2);
        expect_frame(3, 32'h2, 2, 1'b1, 1'b1, 0);
        send_word(3, 4'h1);
        expect_frame(3, 32'h1, 2, 1'b1, 1'b1, 0);
        expect_idle(3, "d after 1");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
